// File: rtl/serial_pair_serializer_if.sv
// Handshake bundle for serial_pair_serializer: parallel operand intake on the
// in_* side, bit-pair stream with frame markers on the out_* side.
interface serial_pair_serializer_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic             out_a;
  logic             out_b;
  logic             out_first;
  logic             out_last;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_first, out_last
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_a, out_b, out_first, out_last
  );
endinterface

// File: rtl/serial_pair_serializer.sv
// Loads two WIDTH-bit operands and streams them one bit pair per cycle with
// first/last frame markers. Define SERIAL_PAIR_SERIALIZER_LSB_FIRST_EN for LSB-first order.
module serial_pair_serializer #(
  parameter int WIDTH = 8
) (
  input logic                     clk,
  input logic                     rst,
  serial_pair_serializer_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_TOP  = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sh_a_q, sh_a_d;
  logic [WIDTH-1:0] sh_b_q, sh_b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             shifting_s;
  logic             last_s;
  logic             accept_s;
  logic             xfer_s;

  assign shifting_s = (state_q == SHIFT);
  assign last_s     = shifting_s && (cnt_q == CNT_ZERO);
  assign xfer_s     = shifting_s && bus.out_ready;
  assign accept_s   = bus.in_valid && bus.in_ready;

  // State and datapath registers; reset aborts any word in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sh_a_q  <= {WIDTH{1'b0}};
      sh_b_q  <= {WIDTH{1'b0}};
      cnt_q   <= CNT_ZERO;
    end else begin
      state_q <= state_d;
      sh_a_q  <= sh_a_d;
      sh_b_q  <= sh_b_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (xfer_s && last_s && !bus.in_valid) begin
          state_d = IDLE;
        end else begin
          state_d = SHIFT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Shift/count datapath: a fresh load wins over the final shift of the previous word.
  always_comb begin
    sh_a_d = sh_a_q;
    sh_b_d = sh_b_q;
    cnt_d  = cnt_q;
    if (accept_s) begin
      sh_a_d = bus.in_a;
      sh_b_d = bus.in_b;
      cnt_d  = CNT_TOP;
    end else if (xfer_s && !last_s) begin
`ifdef SERIAL_PAIR_SERIALIZER_LSB_FIRST_EN
      sh_a_d = sh_a_q >> 1;
      sh_b_d = sh_b_q >> 1;
`else
      sh_a_d = sh_a_q << 1;
      sh_b_d = sh_b_q << 1;
`endif
      cnt_d  = cnt_q - CNT_ONE;
    end else begin
      cnt_d  = cnt_q;
    end
  end

  // Outputs; in_ready is combinational from out_ready so words run back to back.
  always_comb begin
    bus.out_valid = 1'b0;
    bus.out_a     = 1'b0;
    bus.out_b     = 1'b0;
    bus.out_first = 1'b0;
    bus.out_last  = 1'b0;
    bus.in_ready  = 1'b0;
    case (state_q)
      IDLE: begin
        bus.in_ready = !rst;
      end
      SHIFT: begin
        bus.out_valid = 1'b1;
`ifdef SERIAL_PAIR_SERIALIZER_LSB_FIRST_EN
        bus.out_a     = sh_a_q[0];
        bus.out_b     = sh_b_q[0];
`else
        bus.out_a     = sh_a_q[WIDTH-1];
        bus.out_b     = sh_b_q[WIDTH-1];
`endif
        bus.out_first = (cnt_q == CNT_TOP);
        bus.out_last  = last_s;
        bus.in_ready  = !rst && last_s && bus.out_ready;
      end
      default: begin
        bus.out_valid = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/serial_pair_serializer.md
# serial_pair_serializer

Transmit-side companion to the serial comparators. The block accepts two WIDTH-bit operands in parallel through a valid/ready handshake and shifts them out one bit pair per cycle, most significant bit first. Frame markers out_first and out_last let the consumer reset its running state at word boundaries. It sits between a parallel operand source and any bit-serial consumer, such as a most-significant-first serial comparator, in a test or datapath harness.

## Interface
- WIDTH, 8, operand width in bits; legal range ≥ 1.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous, active-high.
- in_valid  input  1  a and b operands are presented.
- in_ready  output  1  block can accept an operand pair this cycle.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- out_valid  output  1  out_a/out_b hold a valid bit pair.
- out_ready  input  1  consumer takes the bit pair; tie to 1 for comparators.
- out_a  output  1  current bit of A.
- out_b  output  1  current bit of B.
- out_first  output  1  current pair is bit WIDTH-1, the first bit of the word.
- out_last  output  1  current pair is bit 0, the final bit of the word.

## Operation
- State machine with two states:
  - IDLE: out_valid=0, in_ready=1.
  - SHIFT: out_valid=1.
- Shift registers sh_a and sh_b, each WIDTH bits.
- Bit counter cnt is $clog2(WIDTH)+1 bits wide and holds the remaining bits minus 1.
- Accept occurs when in_valid & in_ready:
  - load sh_a=in_a and sh_b=in_b;
  - set cnt=WIDTH-1;
  - go to SHIFT.
- In SHIFT:
  - out_a=sh_a[WIDTH-1] and out_b=sh_b[WIDTH-1].
  - out_first=(cnt==WIDTH-1).
  - out_last=(cnt==0).
- Transfer occurs when out_valid & out_ready:
  - if cnt≠0: shift sh_a and sh_b left by 1, and decrement cnt;
  - if cnt=0 and in_valid: load the new word, which is a back-to-back accept; stay in SHIFT;
  - if cnt=0 and no in_valid: go to IDLE.
- in_ready = IDLE | (SHIFT & out_last & out_ready). This path is combinational from out_ready.
- If out_valid & ~out_ready, then out_a, out_b, out_first, out_last and cnt hold unchanged.
- While out_valid=0: out_a, out_b, out_first and out_last are all driven to 0.
- WIDTH=1: out_first and out_last are both 1 on the single pair.
- Operands are unsigned. No arithmetic is performed on the data.

## Timing
- Reset values:
  - state IDLE;
  - out_valid=0, out_a=0, out_b=0, out_first=0, out_last=0;
  - in_ready=1 once rst deasserts; in_ready=0 while rst is high.
- Assertion of rst mid-word aborts the word immediately (asynchronous):
  - out_valid falls without waiting for a clock edge;
  - the remaining bits are discarded and no out_last is emitted.
- Latency: accept at edge N gives the first pair (out_first=1) valid in cycle N+1.
- With out_ready held at 1, the last pair is in cycle N+WIDTH.
- Throughput: one word per WIDTH cycles, with no bubble between back-to-back words.
- in_valid arriving while SHIFT is not on its last transfer is not accepted. The source must hold in_valid and the operands until in_ready.
- A simultaneous last-bit transfer and new accept in the same cycle is legal. The following cycle shows out_first=1 for the new word.

## Configuration
- SERIAL_PAIR_SERIALIZER_LSB_FIRST_EN:
  - Defined: bits leave least significant first. out_a=sh_a[0], the registers shift right, out_first marks bit 0 and out_last marks bit WIDTH-1. This mode feeds least-significant-first comparators.
  - Undefined (default): most significant first, as described above.
- Handshake, timing and reset behaviour are identical in both modes.

## Test plan
- Basic order: WIDTH=4, in_a=4'b1010, in_b=4'b0110, out_ready=1, accept at edge N.
  - out_a = 1,0,1,0 and out_b = 0,1,1,0 in cycles N+1..N+4.
  - out_first=1 only at N+1; out_last=1 only at N+4; out_valid=0 at N+5.
- Backpressure: same word with out_ready=0 during cycle N+2 only.
  - Pair (0,1) is held for 2 cycles, all outputs are stable during the hold, and out_last falls in cycle N+5.
- Back-to-back: in_valid held with words (4'hF, 4'h0) then (4'h3, 4'h3).
  - in_ready pulses in cycle N+4; the second word's out_first is in cycle N+5; out_valid never drops.
- Reset mid-word: assert rst asynchronously during cycle N+2.
  - out_valid=0 before the next edge; after release, in_ready=1 and no stale bits are emitted.
- End-to-end: chain into the MSB-first comparator, with comparator rst driven by out_first.
  - Operands (5,5), (9,3) and (3,9) give a_eq_b, a_greater_b and a_less_b respectively at out_last.
- LSB mode with the macro defined: in_a=4'b0001, in_b=4'b1000.
  - out_a = 1,0,0,0 and out_b = 0,0,0,1.
